sha3_msg_loader: RTL and testbench
==================================

# sha3_msg_loader

Front-end for the H hash in the Kyber datapath. Accepts the message to be hashed as a byte stream and packs it right-aligned into the 12544-bit `M` operand of `SHA3_256`. It also latches and holds `kyber_mode`/`H_mode`, pulses `active`, and waits for `finish`. It then captures the 256-bit digest and presents it on a valid/ready output. It sits between the byte-serial encoders (pk/ciphertext packers, 32-byte m source) and `SHA3_256`.

## Interface
Parameters:
- `MAX_BYTES`, 1568 — width of `M` in bytes (12544 bits); fixed by `SHA3_256`.
- `TIMEOUT`, 4095 — WAIT-state cycle limit, used only with the timeout feature.

Ports:
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — reset is synchronous and active-high.
- `start` in 1 — begin a message; sampled only in IDLE.
- `kyber_mode_i` in 2 — 0: 512, 1: 768, 2: 1024; latched on accepted `start`.
- `H_mode_i` in 2 — 0: M, 1: PK, 2: C; latched on accepted `start`.
- `in_valid` in 1 — byte available.
- `in_ready` out 1 — loader accepts a byte.
- `in_data` in 8 — message byte, first byte first.
- `M` out [0:12543] — packed operand to `SHA3_256.M`.
- `kyber_mode` out 2 — latched mode to `SHA3_256`.
- `H_mode` out 2 — latched mode to `SHA3_256`.
- `active` out 1 — one-cycle kick to `SHA3_256`.
- `finish` in 1 — from `SHA3_256`.
- `Z_rv` in [0:255] — digest from `SHA3_256`.
- `hash` out [0:255] — captured digest.
- `hash_valid` out 1 — `hash` is valid.
- `hash_ready` in 1 — consumer takes `hash`.
- `busy` out 1 — high in every state except IDLE.
- `err` out 1 — timeout pulse; tied 0 when the feature is compiled out.

## Operation
- Message length L (bytes) from the latched modes:
  - PK: 800, 1184, 1568 for 512, 768, 1024.
  - C: 768, 1088, 1568.
  - M: 32.
  - Every other combination (H_mode 3, kyber_mode 3): 32.
- Packing: byte k (0..L-1) is written to `M[8*(1568-L+k) +: 8]`, with `in_data[7]` at the lowest `M` index. Bytes 0..1567-L of `M` are zero.
- Byte counter: 11 bits, 0..L-1. It increments on each `in_valid && in_ready`.
- FSM:
  - IDLE: waits for `start`. On `start`, latches modes, clears `M` to 0 and the counter to 0, then goes to LOAD.
  - LOAD: `in_ready` = 1. Acceptance of byte L-1 goes to FIRE.
  - FIRE: `active` = 1 for exactly one cycle, then WAIT.
  - WAIT: `finish` = 1 captures `Z_rv` into `hash` and goes to DONE.
  - DONE: `hash_valid` = 1. A `hash_valid && hash_ready` handshake returns to IDLE.
- `M`, `kyber_mode` and `H_mode` stay stable from LOAD exit until the next accepted `start`. `SHA3_256` reads them throughout hashing.
- `start` outside IDLE is ignored. `finish` outside WAIT is ignored. `in_valid` outside LOAD is ignored.
- Reset (asserted at any time, including mid-load or mid-hash) forces IDLE on the next edge. All outputs take their reset values: `in_ready` 0, `active` 0, `hash_valid` 0, `busy` 0, `err` 0, `hash` 0, `M` 0, `kyber_mode` 0, `H_mode` 0.

## Timing
- `start` high at edge t → LOAD from t+1; `in_ready` high from cycle t+1.
- Throughput: one byte per cycle. The loader never deasserts `in_ready` inside LOAD.
- Last byte accepted at edge T:
  - `active` high during cycle T+1.
  - WAIT from T+2.
  - `M` is final from T+1.
- `finish` high in cycle F → `hash` and `hash_valid` valid from F+1.
- Handshake at edge H → IDLE and `hash_valid` = 0 from H+1. A new `start` is accepted at H+1 at the earliest.
- Minimum message turnaround: L + 3 cycles plus `SHA3_256` latency plus the output stall.

## Configuration
- `SHA3_MSG_LOADER_TIMEOUT_EN` defined:
  - A 12-bit counter clears on WAIT entry and counts cycles in WAIT.
  - If it reaches `TIMEOUT` without `finish`, `err` pulses for one cycle and the FSM returns to IDLE. `hash` and `hash_valid` are left untouched.
- Macro undefined:
  - No counter; WAIT waits indefinitely.
  - `err` is constant 0.

## Test plan
- M mode, bytes 0x00..0x1F:
  - `M[12288+8k +: 8]` = k; all other bits 0.
  - Exactly one `active` pulse, in cycle T+1.
  - `hash` equals the software SHA3-256 of the 32 bytes.
- PK/768 (H_mode 1, kyber_mode 1), 1184 bytes of counter pattern k mod 256:
  - First byte lands at `M[3072 +: 8]`; `M[0:3071]` = 0.
  - Digest matches the software model.
- Back-to-back messages:
  - Run C/1024 (1568 bytes, 0xFF) then M (32 bytes, 0x00).
  - The second `M` has bytes 0..1535 cleared.
  - Both digests are correct.
- Output backpressure:
  - Hold `hash_ready` = 0 for 100 cycles after `finish`.
  - `hash_valid` and `hash` stay stable; `start` pulses during DONE are ignored.
  - Release → IDLE on the next cycle.
- Reset mid-load:
  - Assert `rst` after 500 of 800 bytes (PK/512).
  - All outputs take their reset values next cycle.
  - A fresh PK/512 message then yields the correct digest.
- Timeout (macro defined): withhold `finish` → `err` pulses exactly `TIMEOUT` cycles after WAIT entry, FSM returns to IDLE, and `hash_valid` stays 0.

Source files
------------

// File: rtl/sha3_msg_loader_if.sv
// Byte-stream input and digest output handshakes of sha3_msg_loader.
// master = upstream/consumer side, slave = the loader.
interface sha3_msg_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [0:255] hash;
  logic         hash_valid;
  logic         hash_ready;

  modport master (
    output in_valid,
    output in_data,
    output hash_ready,
    input  in_ready,
    input  hash,
    input  hash_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  hash_ready,
    output in_ready,
    output hash,
    output hash_valid
  );
endinterface

// File: rtl/sha3_msg_loader.sv
// Packs a byte-serial message right-aligned into the SHA3_256 M operand, kicks the core and
// returns the digest on a valid/ready port. Optional WAIT watchdog: SHA3_MSG_LOADER_TIMEOUT_EN.
module sha3_msg_loader #(
  parameter int MAX_BYTES = 1568,
  parameter int TIMEOUT   = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             kyber_mode_i,
  input  logic [1:0]             H_mode_i,
  sha3_msg_loader_if.slave       bus,
  output logic [0:MAX_BYTES*8-1] M,
  output logic [1:0]             kyber_mode,
  output logic [1:0]             H_mode,
  output logic                   active,
  input  logic                   finish,
  input  logic [0:255]           Z_rv,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FIRE = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [0:MAX_BYTES*8-1] m_r;
  logic [1:0]             km_r;
  logic [1:0]             hm_r;
  logic [10:0]            cnt_r;
  logic [0:255]           hash_r;
  logic                   in_ready_r;
  logic                   active_r;
  logic                   hash_valid_r;
  logic                   busy_r;
  logic [10:0]            len_s;
  logic [10:0]            byte_pos_s;
  logic [13:0]            bit_idx_s;
  logic                   last_s;
  logic                   to_hit_s;

  // Message length in bytes for the latched (H_mode, kyber_mode) pair; unused codes fall back to 32.
  function automatic logic [10:0] msg_len_f(input logic [1:0] km, input logic [1:0] hm);
    logic [10:0] len;
    len = 11'd32;
    case (hm)
      2'd1: begin
        case (km)
          2'd0:    len = 11'd800;
          2'd1:    len = 11'd1184;
          2'd2:    len = 11'd1568;
          default: len = 11'd32;
        endcase
      end
      2'd2: begin
        case (km)
          2'd0:    len = 11'd768;
          2'd1:    len = 11'd1088;
          2'd2:    len = 11'd1568;
          default: len = 11'd32;
        endcase
      end
      default: len = 11'd32;
    endcase
    return len;
  endfunction

  assign len_s      = msg_len_f(km_r, hm_r);
  assign byte_pos_s = 11'(MAX_BYTES) - len_s + cnt_r;
  assign bit_idx_s  = {byte_pos_s, 3'b000};
  assign last_s     = (cnt_r == (len_s - 11'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_LOAD;
        else       state_nxt_s = S_IDLE;
      end
      S_LOAD: begin
        if (bus.in_valid && last_s) state_nxt_s = S_FIRE;
        else                        state_nxt_s = S_LOAD;
      end
      S_FIRE: begin
        state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
        if (finish)        state_nxt_s = S_DONE;
        else if (to_hit_s) state_nxt_s = S_IDLE;
        else               state_nxt_s = S_WAIT;
      end
      S_DONE: begin
        if (hash_valid_r && bus.hash_ready) state_nxt_s = S_IDLE;
        else                                state_nxt_s = S_DONE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Mode latch, operand clear/pack and digest capture; M holds still outside LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r    <= '0;
      km_r   <= 2'd0;
      hm_r   <= 2'd0;
      cnt_r  <= 11'd0;
      hash_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            km_r  <= kyber_mode_i;
            hm_r  <= H_mode_i;
            m_r   <= '0;
            cnt_r <= 11'd0;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            m_r[bit_idx_s +: 8] <= bus.in_data;
            cnt_r               <= cnt_r + 11'd1;
          end
        end
        S_WAIT: begin
          if (finish) begin
            hash_r <= Z_rv;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs are registered from the next state so they coincide with the state they flag
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r   <= 1'b0;
      active_r     <= 1'b0;
      hash_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      in_ready_r   <= (state_nxt_s == S_LOAD);
      active_r     <= (state_nxt_s == S_FIRE);
      hash_valid_r <= (state_nxt_s == S_DONE);
      busy_r       <= (state_nxt_s != S_IDLE);
    end
  end

`ifdef SHA3_MSG_LOADER_TIMEOUT_EN
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  logic [11:0] to_cnt_r;
  logic        err_r;

  assign to_hit_s = (state_r == S_WAIT) && (to_cnt_r == TO_LAST);

  // WAIT watchdog: counter restarts from 0 on every WAIT entry; err flags a hash that never finished
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= 12'd0;
      err_r    <= 1'b0;
    end else begin
      if (state_r == S_WAIT) to_cnt_r <= to_cnt_r + 12'd1;
      else                   to_cnt_r <= 12'd0;
      err_r <= to_hit_s && !finish;
    end
  end

  assign err = err_r;
`else
  localparam int unused_timeout = TIMEOUT;

  assign to_hit_s = 1'b0;
  assign err      = 1'b0;
`endif

  assign M              = m_r;
  assign kyber_mode     = km_r;
  assign H_mode         = hm_r;
  assign active         = active_r;
  assign busy           = busy_r;
  assign bus.in_ready   = in_ready_r;
  assign bus.hash       = hash_r;
  assign bus.hash_valid = hash_valid_r;

endmodule

// File: tb/tb_sha3_msg_loader.sv
// Scoreboard bench for sha3_msg_loader: a stub SHA3 core returns a positional fold of M,
// expected operands/digests are queued at stimulus time and checked by a negedge monitor.
module tb_sha3_msg_loader;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   kyber_mode_i;
  logic [1:0]   H_mode_i;
  logic [0:12543] M;
  logic [1:0]   kyber_mode;
  logic [1:0]   H_mode;
  logic         active;
  logic         finish = 1'b0;
  logic [0:255] Z_rv = '0;
  logic         busy;
  logic         err;

  sha3_msg_loader_if bus();

  sha3_msg_loader #(.MAX_BYTES(1568), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .kyber_mode_i (kyber_mode_i),
    .H_mode_i     (H_mode_i),
    .bus          (bus),
    .M            (M),
    .kyber_mode   (kyber_mode),
    .H_mode       (H_mode),
    .active       (active),
    .finish       (finish),
    .Z_rv         (Z_rv),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_msgs = 0;
  int n_active = 0;
  int core_cnt = 0;
  bit core_mute = 1'b0;
  bit active_prev = 1'b0;
  logic [0:12543] exp_m_q[$];
  logic [0:255]   exp_h_q[$];

  function automatic logic [0:255] fold(input logic [0:12543] m);
    logic [0:255] z;
    z = '0;
    for (int i = 0; i < 49; i++) z = {z[1:255], z[0]} ^ m[256*i +: 256];
    return z;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_hash(input string name, input logic [0:255] act, input logic [0:255] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_m(input string name, input logic [0:12543] act, input logic [0:12543] exp);
    int first;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      first = -1;
      for (int k = 0; k < 1568; k++)
        if (first < 0 && act[8*k +: 8] !== exp[8*k +: 8]) first = k;
      $display("FAIL %s: first bad byte %0d got %h expected %h", name, first,
               act[8*first +: 8], exp[8*first +: 8]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stub SHA3 core plus scoreboard monitor
  always @(negedge clk) begin
    if (finish) finish = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        Z_rv   = fold(M);
        finish = 1'b1;
      end
    end
    if (rst) begin
      active_prev = 1'b0;
      core_cnt    = 0;
    end else begin
      if (active) begin
        n_active++;
        check_bit("active_single_cycle", active_prev, 1'b0);
        if (exp_m_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL M_unexpected_active: got pulse expected none");
        end else begin
          check_m("M_at_active", M, exp_m_q.pop_front());
        end
        if (!core_mute) core_cnt = 4;
      end
      if (bus.hash_valid && bus.hash_ready) begin
        if (exp_h_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL hash_unexpected: got %h expected none", bus.hash);
        end else begin
          check_hash("hash", bus.hash, exp_h_q.pop_front());
        end
        check_bit("err_low", err, 1'b0);
      end
      active_prev = active;
    end
  end

  task automatic check_reset_state(input string tag);
    check_bit({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check_bit({tag, "_active"}, active, 1'b0);
    check_bit({tag, "_hash_valid"}, bus.hash_valid, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_err"}, err, 1'b0);
    check_hash({tag, "_hash"}, bus.hash, 256'd0);
    check_bit({tag, "_M_zero"}, |M, 1'b0);
    check_int({tag, "_kyber_mode"}, int'(kyber_mode), 0);
    check_int({tag, "_H_mode"}, int'(H_mode), 0);
  endtask

  // pat < 0 selects the counter pattern k mod 256, otherwise every byte is pat
  task automatic send_msg(input logic [1:0] hm, input logic [1:0] km, input int len,
                          input int nsend, input int pat, input bit push_h);
    logic [0:12543] em;
    int held_low;
    em = '0;
    for (int k = 0; k < len; k++)
      em[8*(1568-len+k) +: 8] = (pat < 0) ? 8'(k) : 8'(pat);
    if (nsend == len) begin
      exp_m_q.push_back(em);
      n_msgs++;
      if (push_h) exp_h_q.push_back(fold(em));
    end
    start = 1'b1; H_mode_i = hm; kyber_mode_i = km;
    tick();
    start = 1'b0;
    check_bit("in_ready_after_start", bus.in_ready, 1'b1);
    held_low = 0;
    for (int k = 0; k < nsend; k++) begin
      if (!bus.in_ready) held_low++;
      bus.in_valid = 1'b1;
      bus.in_data  = (pat < 0) ? 8'(k) : 8'(pat);
      tick();
    end
    bus.in_valid = 1'b0;
    check_int("in_ready_held", held_low, 0);
    if (nsend == len) begin
      check_bit("active_T+1", active, 1'b1);
      check_bit("in_ready_fire", bus.in_ready, 1'b0);
    end
  endtask

  task automatic wait_hash(input int budget);
    int i;
    i = 0;
    while (exp_h_q.size() != 0 && i < budget) begin
      tick();
      i++;
    end
    if (exp_h_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL hash_wait: got %0d pending expected 0", exp_h_q.size());
      exp_h_q.delete();
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:255] h0;
    bit stable;
    int err_at;
    int err_n;
    rst = 1'b1; start = 1'b0; kyber_mode_i = 2'd0; H_mode_i = 2'd0;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.hash_ready = 1'b1;
    tick(); tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // M mode, bytes 0x00..0x1F
    send_msg(2'd0, 2'd0, 32, 32, -1, 1'b1);
    check_int("m_byte0", int'(M[12288 +: 8]), 0);
    check_int("m_byte1", int'(M[12296 +: 8]), 1);
    check_int("m_byte31", int'(M[12536 +: 8]), 31);
    check_bit("m_prefix_zero", |M[0:12287], 1'b0);
    check_bit("m_busy", busy, 1'b1);
    wait_hash(50);
    check_bit("idle_after_hs", busy, 1'b0);

    // PK/768 counter pattern
    send_msg(2'd1, 2'd1, 1184, 1184, -1, 1'b1);
    check_int("pk768_first", int'(M[3072 +: 8]), 0);
    check_int("pk768_second", int'(M[3080 +: 8]), 1);
    check_bit("pk768_prefix_zero", |M[0:3071], 1'b0);
    check_int("pk768_kmode", int'(kyber_mode), 1);
    check_int("pk768_hmode", int'(H_mode), 1);
    wait_hash(50);

    // Back-to-back C/1024 all-ones then M all-zero
    send_msg(2'd2, 2'd2, 1568, 1568, 255, 1'b1);
    check_int("c1024_first", int'(M[0 +: 8]), 255);
    wait_hash(50);
    send_msg(2'd0, 2'd0, 32, 32, 0, 1'b1);
    check_bit("m2_prefix_clear", |M, 1'b0);
    wait_hash(50);

    // Output backpressure with ignored start in DONE
    bus.hash_ready = 1'b0;
    send_msg(2'd0, 2'd1, 32, 32, 8'hA5, 1'b1);
    for (int i = 0; i < 50 && !bus.hash_valid; i++) tick();
    check_bit("bp_valid_seen", bus.hash_valid, 1'b1);
    h0 = bus.hash;
    stable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (c == 50) begin start = 1'b1; kyber_mode_i = 2'd2; H_mode_i = 2'd2; end
      if (c == 51) start = 1'b0;
      tick();
      if (!bus.hash_valid || bus.hash !== h0) stable = 1'b0;
    end
    start = 1'b0;
    check_bit("bp_stable", stable, 1'b1);
    check_int("bp_kmode_kept", int'(kyber_mode), 1);
    check_int("bp_hmode_kept", int'(H_mode), 0);
    check_bit("bp_busy", busy, 1'b1);
    bus.hash_ready = 1'b1;
    tick();
    check_bit("bp_release_idle", busy, 1'b0);
    check_bit("bp_release_valid", bus.hash_valid, 1'b0);
    wait_hash(5);

    // Reset mid-load of PK/512, then a clean PK/512
    send_msg(2'd1, 2'd0, 800, 500, -1, 1'b1);
    check_bit("midload_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    check_reset_state("midload");
    rst = 1'b0;
    tick();
    send_msg(2'd1, 2'd0, 800, 800, 8'h3C, 1'b1);
    check_int("pk512_first", int'(M[6144 +: 8]), 8'h3C);
    wait_hash(50);

`ifdef SHA3_MSG_LOADER_TIMEOUT_EN
    // Withheld finish: err exactly TO cycles after WAIT entry (WAIT entered at T+2)
    core_mute = 1'b1;
    send_msg(2'd0, 2'd0, 32, 32, 7, 1'b0);
    err_at = -1;
    err_n = 0;
    for (int i = 1; i <= TO + 3; i++) begin
      tick();
      if (err) begin
        err_n++;
        if (err_at < 0) err_at = i;
      end
    end
    check_int("timeout_err_cycle", err_at, TO + 1);
    check_int("timeout_err_width", err_n, 1);
    check_bit("timeout_idle", busy, 1'b0);
    check_bit("timeout_no_valid", bus.hash_valid, 1'b0);
    core_mute = 1'b0;
`else
    err_at = 0;
    err_n = 0;
    check_bit("err_tied_low", err, 1'b0);
`endif

    tick();
    check_int("active_pulses", n_active, n_msgs);
    check_int("m_queue_drained", exp_m_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
